// File: rtl/uart_tx_if.sv
// Transmitter-side signal bundle: bit tick, TXSTA controls, TXREG write port
// and the serial line / status flags returned by the transmitter.
// master: drives controls and TXREG writes; slave: the transmitter itself.
interface uart_tx_if;
  logic       uart_tx_shift_en;  // one-cycle bit-period tick
  logic       txen;              // TXSTA.TXEN level
  logic       tx9;               // TXSTA.TX9 level
  logic       tx9d;              // TXSTA.TX9D level
  logic       txreg_wr_en;       // TXREG write strobe
  logic [7:0] txreg_in;          // TXREG write data
  logic       tx_out;            // serial line, idle high
  logic       trmt;              // TSR empty
  logic       txif;              // TXREG empty flag

  modport master (
    output uart_tx_shift_en, txen, tx9, tx9d, txreg_wr_en, txreg_in,
    input  tx_out, trmt, txif
  );

  modport slave (
    input  uart_tx_shift_en, txen, tx9, tx9d, txreg_wr_en, txreg_in,
    output tx_out, trmt, txif
  );
endinterface

// File: rtl/uart_tx.sv
// Asynchronous UART transmitter: TXREG holding buffer feeding a TSR shift
// register, framing start + 8 data (LSB first) + optional 9th bit + stop.
// Ports: clk, rst (sync, active-high), bus (uart_tx_if.slave: tick, TXSTA
// levels, TXREG write port, tx_out/trmt/txif). Optional 9th bit: UART_TX_9BIT_EN.
module uart_tx (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_BIT9  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] txreg_q, txreg_d;
  logic       valid_q, valid_d;
  logic [7:0] tsr_q,   tsr_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       tx_out_q, tx_out_d;
  logic       trmt_q,  trmt_d;
  logic       wr;
  logic       load;
  logic       tick;

`ifdef UART_TX_9BIT_EN
  logic       bit9_q, bit9_d;   // tx9d captured at TSR load
  logic       nine_q, nine_d;   // tx9 captured at TSR load: frame has BIT9
`else
  logic       unused_tx9;
  assign unused_tx9 = bus.tx9 ^ bus.tx9d;
`endif

  assign tick = bus.uart_tx_shift_en;
  assign wr   = bus.txreg_wr_en & bus.txen;

  always_comb begin
    state_d = state_q;
    txreg_d = txreg_q;
    valid_d = valid_q;
    tsr_d   = tsr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef UART_TX_9BIT_EN
    bit9_d  = bit9_q;
    nine_d  = nine_q;
`endif

    case (state_q)
      // Load ignores the tick, so WAIT always runs to the following tick.
      S_IDLE: begin
        if (valid_q) begin
          load    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT:  if (tick) state_d = S_START;
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          tsr_d = {1'b0, tsr_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
`ifdef UART_TX_9BIT_EN
            state_d = nine_q ? S_BIT9 : S_STOP;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_BIT9:  if (tick) state_d = S_STOP;
      S_STOP: begin
        if (tick) begin
          // A pending byte goes straight to START: no idle bit between frames.
          if (valid_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      tsr_d   = txreg_q;
      valid_d = 1'b0;
`ifdef UART_TX_9BIT_EN
      bit9_d  = bus.tx9d;
      nine_d  = bus.tx9;
`endif
    end

    // A write in the same cycle as a load keeps the new byte pending.
    if (wr) begin
      txreg_d = bus.txreg_in;
      valid_d = 1'b1;
    end

    // Dropping TXEN abandons the frame and discards any pending byte.
    if (!bus.txen) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end

    // The line register follows the next state, so every line change lands
    // on the cycle after the tick that caused it.
    case (state_d)
      S_START: tx_out_d = 1'b0;
      S_DATA:  tx_out_d = tsr_d[0];
`ifdef UART_TX_9BIT_EN
      S_BIT9:  tx_out_d = bit9_d;
`endif
      default: tx_out_d = 1'b1;
    endcase

    trmt_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      txreg_q  <= 8'h00;
      valid_q  <= 1'b0;
      tsr_q    <= 8'h00;
      cnt_q    <= 3'd0;
      tx_out_q <= 1'b1;
      trmt_q   <= 1'b1;
`ifdef UART_TX_9BIT_EN
      bit9_q   <= 1'b0;
      nine_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      txreg_q  <= txreg_d;
      valid_q  <= valid_d;
      tsr_q    <= tsr_d;
      cnt_q    <= cnt_d;
      tx_out_q <= tx_out_d;
      trmt_q   <= trmt_d;
`ifdef UART_TX_9BIT_EN
      bit9_q   <= bit9_d;
      nine_q   <= nine_d;
`endif
    end
  end

  assign bus.tx_out = tx_out_q;
  assign bus.trmt   = trmt_q;
  // TXIF is simply "no byte pending in TXREG".
  assign bus.txif   = ~valid_q;

endmodule
